// File: rtl/pipe_execute_cc.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition, optional
// iterative mulq, and the E->M pipeline register.
module pipe_execute_cc #(
  parameter int         WIDTH  = 64,
  parameter bit         MUL_EN = 1'b1,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             cc_inhibit,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic             busy,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] PLUS8  = WIDTH'(8);
  localparam logic [WIDTH-1:0] MINUS8 = ~WIDTH'(7);

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] alu_a, alu_b, alu_r, sum, diff;
  logic             of_c, cnd_raw, zf, sf, of;
  logic [2:0]       cc;
  logic             is_mul, issue, last, complete, cc_load;

  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [CW-1:0]    count;
  logic [2:0]       mul_stat;
  logic [3:0]       mul_dstE;

  assign {zf, sf, of} = cc;
  assign sum  = alu_b + alu_a;
  assign diff = alu_b - alu_a;

  always_comb begin
    alu_a = '0;
    case (E_icode)
      4'h2, 4'h6:       alu_a = E_valA;
      4'h3, 4'h4, 4'h5: alu_a = E_valC;
      4'h8, 4'hA:       alu_a = MINUS8;
      4'h9, 4'hB:       alu_a = PLUS8;
      default:          alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (E_icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = E_valB;
      default:                                  alu_b = '0;
    endcase
  end

  // Non-OPq instructions always add; mulq has no combinational result.
  always_comb begin
    alu_r = sum;
    of_c  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_b[WIDTH-1]);
    if (E_icode == 4'h6) begin
      case (E_ifun)
        4'h1: begin
          alu_r = diff;
          of_c  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_b[WIDTH-1]);
        end
        4'h2: begin alu_r = alu_b & alu_a; of_c = 1'b0; end
        4'h3: begin alu_r = alu_b ^ alu_a; of_c = 1'b0; end
        4'h4: if (MUL_EN) begin alu_r = '0; of_c = 1'b0; end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnd_raw = 1'b0;
    case (E_ifun)
      4'h0: cnd_raw = 1'b1;
      4'h1: cnd_raw = (sf ^ of) | zf;
      4'h2: cnd_raw = sf ^ of;
      4'h3: cnd_raw = zf;
      4'h4: cnd_raw = !zf;
      4'h5: cnd_raw = !(sf ^ of);
      4'h6: cnd_raw = !(sf ^ of) && !zf;
      default: cnd_raw = 1'b0;
    endcase
  end

  assign e_Cnd  = ((E_icode == 4'h2) || (E_icode == 4'h7)) && cnd_raw;
  assign e_dstE = ((E_icode == 4'h2) && !e_Cnd) ? RNONE : E_dstE;
  assign busy   = (state == MUL);
  assign e_valE = busy ? '0 : alu_r;

  assign is_mul   = MUL_EN && (E_icode == 4'h6) && (E_ifun == 4'h4);
  assign issue    = (state == IDLE) && is_mul && !M_bubble && !M_stall;
  assign last     = busy && (count == CW'(1));
  assign complete = last && !M_stall && !M_bubble;
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign cc_load  = (E_icode == 4'h6) && !is_mul && !busy && !cc_inhibit && !M_stall && !M_bubble;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (issue) state_nxt = MUL;
      MUL:  if (M_bubble || complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The last step stays combinational (acc_nxt) so a stalled completion just holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      mul_stat <= 3'd1;
      mul_dstE <= RNONE;
    end else if (issue) begin
      mcand    <= E_valB;
      mplier   <= E_valA;
      acc      <= '0;
      count    <= CW'(WIDTH);
      mul_stat <= E_stat;
      mul_dstE <= E_dstE;
    end else if (busy && !last) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cc <= 3'b100;
    else if (complete && !cc_inhibit) cc <= {acc_nxt == '0, acc_nxt[WIDTH-1], 1'b0};
    else if (cc_load)                 cc <= {alu_r == '0, alu_r[WIDTH-1], of_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || M_bubble) begin
      M_stat <= 3'd1; M_icode <= 4'h1; M_Cnd <= 1'b0;
      M_valE <= '0;   M_valA  <= '0;   M_dstE <= RNONE; M_dstM <= RNONE;
    end else if (complete) begin
      M_stat <= mul_stat; M_icode <= 4'h6; M_Cnd <= 1'b0;
      M_valE <= acc_nxt;  M_valA  <= '0;   M_dstE <= mul_dstE; M_dstM <= RNONE;
    end else if (busy || (issue && !M_stall)) begin
      M_stat <= 3'd1; M_icode <= 4'h1; M_Cnd <= 1'b0;
      M_valE <= '0;   M_valA  <= '0;   M_dstE <= RNONE; M_dstM <= RNONE;
    end else if (!M_stall) begin
      M_stat <= E_stat; M_icode <= E_icode; M_Cnd  <= e_Cnd;
      M_valE <= e_valE; M_valA  <= E_valA;  M_dstE <= e_dstE; M_dstM <= E_dstM;
    end
  end

endmodule

// File: doc/pipe_execute_cc.md
Name: pipe_execute_cc

Overview:
- Parametrised E stage for the pipelined Y86-64 core. It computes valE, holds the condition-code register and evaluates Cnd for jXX/cmovXX.
- Adds an optional iterative mulq, then registers all results into the E->M pipeline register.
- Sits between the D->E register and the memory stage.
- Exports combinational e_dstE/e_valE for forwarding and busy for the hazard controller.

Parameters:
- WIDTH, 64, data path width in bits (≥16, multiple of 8).
- MUL_EN, 1, enables OPq ifun=4 (mulq); when 0, ifun=4 behaves as addq.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- E_stat  in  3  status of instruction in E (1=AOK)
- E_icode  in  4  instruction code
- E_ifun  in  4  function code
- E_valA  in  WIDTH  operand A
- E_valB  in  WIDTH  operand B
- E_valC  in  WIDTH  immediate/displacement
- E_dstE  in  4  destination for valE
- E_dstM  in  4  destination for memory load
- cc_inhibit  in  1  high when M or W carries a non-AOK status; blocks CC update
- M_stall  in  1  hold the E->M register
- M_bubble  in  1  load a nop into the E->M register; aborts any multiply
- e_valE  out  WIDTH  combinational ALU result (forwarding)
- e_dstE  out  4  combinational effective dstE (RNONE when cmov fails)
- e_Cnd  out  1  combinational condition result
- busy  out  1  multiply in progress; controller must stall F/D/E
- M_stat  out  3  registered
- M_icode  out  4  registered
- M_Cnd  out  1  registered
- M_valE  out  WIDTH  registered
- M_valA  out  WIDTH  registered
- M_dstE  out  4  registered
- M_dstM  out  4  registered

Behaviour:
- aluA selection:
  - icode 2,6: valA
  - icode 3,4,5: valC
  - icode 8,A: -8
  - icode 9,B: +8
  - all others: 0
- aluB selection:
  - icode 4,5,6,8,9,A,B: valB
  - all others: 0
- ALU functions (all results modulo 2^WIDTH):
  - ifun 0 (add): B+A
  - ifun 1 (sub): B-A
  - ifun 2: B&A
  - ifun 3: B^A
  - ifun 4: B*A, low WIDTH bits
  - A non-OPq instruction always uses add.
- Overflow flag:
  - add: (A[msb]==B[msb]) && (R[msb]!=B[msb])
  - sub: (A[msb]!=B[msb]) && (R[msb]!=B[msb])
  - logical and mul: OF=0
- CC register {ZF,SF,OF}:
  - Reset value {1,0,0}.
  - Updates at the clock edge only when icode==6, !cc_inhibit, !M_stall and !M_bubble.
  - For mulq, CC updates on the completion edge instead.
- Cnd uses the CC value before the current update; ifun 0..6 map to always, le, l, e, ne, ge, g.
  - ifun>6 gives Cnd=0.
  - For icode other than 2 or 7, Cnd=0.
- e_dstE = RNONE when icode==2 && !Cnd; otherwise E_dstE.
- E->M register update priority: rst_n low > M_bubble > busy > M_stall > load.
  - Bubble/reset value: stat=1, icode=1, Cnd=0, valE=0, valA=0, dstE=dstM=RNONE.
  - While busy (not bubbled), M is loaded with a bubble each cycle.
- Multiply FSM, states IDLE and MUL:
  - IDLE->MUL when icode==6, ifun==4, MUL_EN and !M_bubble. Operands are latched, count=WIDTH, busy=1.
  - MUL: shift-add, one multiplier bit per cycle, count decrements.
  - At count==1 the product is committed to M together with the latched icode/dstE/stat and CC, busy drops, then return to IDLE.
  - Issue-to-M latency is WIDTH cycles; busy is high for WIDTH cycles starting the cycle after issue. e_valE is undefined-free (0) while busy.
  - M_bubble or reset in MUL returns to IDLE: busy=0, no CC update, no result.
  - M_stall during the MUL completion cycle holds the result internally until the stall releases; busy stays high meanwhile.
- No X propagation: every output has a defined value out of reset.

Test Plan:
- Reset, then release with no other stimulus -> M_icode=1, M_dstE=F, busy=0, CC={1,0,0}; jne (icode7,ifun4) gives e_Cnd=0.
- subq, valA=1, valB=0x8000_0000_0000_0000 -> valE=0x7FFF_FFFF_FFFF_FFFF, OF=1, SF=0, ZF=0. A following jl gives Cnd=1.
- addq with cc_inhibit=1, result 0 -> M_valE=0, CC unchanged from prior value.
- cmovle (2,1) with CC {0,0,0}, dstE=3 -> e_dstE=F, M_dstE=F, M_Cnd=0.
- mulq, valA=7, valB=6 (WIDTH=64) -> busy high 64 cycles with M bubbles. M_valE=42 exactly once, then ZF=0. M_bubble in cycle 10 aborts: no result, CC unchanged.
- pushq valB=0x100 with M_stall=1 for 2 cycles -> M_* hold the prior values, then M_valE=0xF8.
